// File: rtl/panda_hazard_scoreboard_pkg.sv
// Shared types and constants for the Panda hazard/forwarding scoreboard.
package panda_hazard_scoreboard_pkg;

    localparam int SB_DEPTH    = 3;
    localparam int SB_NUM_REGS = 32;
    localparam int SB_REG_W    = $clog2(SB_NUM_REGS);
    localparam int SB_LAT_W    = $clog2(SB_DEPTH + 1);

    typedef enum logic [1:0] {
        SRC_NONE = 2'b00,
        SRC_EX   = 2'b01,
        SRC_ID   = 2'b10
    } src_use_e;

    localparam logic [SB_LAT_W-1:0] LAT_ALU  = SB_LAT_W'(1);
    localparam logic [SB_LAT_W-1:0] LAT_LOAD = SB_LAT_W'(2);

    typedef struct packed {
        logic                valid;
        logic [SB_REG_W-1:0] rd_addr;
        logic [SB_LAT_W-1:0] lat;
    } sb_slot_t;

endpackage

// File: rtl/panda_hazard_scoreboard_if.sv
// Decode-side bundle between the ID stage and the hazard scoreboard.
interface panda_hazard_scoreboard_if #(
    parameter int Depth   = 3,
    parameter int NumRegs = 32,
    parameter int LatW    = $clog2(Depth + 1)
);
    import panda_hazard_scoreboard_pkg::*;

    localparam int RegW = $clog2(NumRegs);

    logic            issue_valid;
    logic [RegW-1:0] issue_rd_addr;
    logic            issue_rd_we;
    logic [LatW-1:0] issue_lat;
    logic [RegW-1:0] rs1_addr;
    logic [RegW-1:0] rs2_addr;
    src_use_e        rs1_use;
    src_use_e        rs2_use;
    logic            flush;
    logic            stall;
    logic [LatW-1:0] id_fwd_rs1_sel;
    logic [LatW-1:0] id_fwd_rs2_sel;
    logic [LatW-1:0] ex_fwd_rs1_sel;
    logic [LatW-1:0] ex_fwd_rs2_sel;
    logic [Depth-1:0] slot_valid;
    logic [31:0]     stall_cnt;

    modport master (
        output issue_valid, issue_rd_addr, issue_rd_we, issue_lat,
               rs1_addr, rs2_addr, rs1_use, rs2_use, flush,
        input  stall, id_fwd_rs1_sel, id_fwd_rs2_sel,
               ex_fwd_rs1_sel, ex_fwd_rs2_sel, slot_valid, stall_cnt
    );

    modport slave (
        input  issue_valid, issue_rd_addr, issue_rd_we, issue_lat,
               rs1_addr, rs2_addr, rs1_use, rs2_use, flush,
        output stall, id_fwd_rs1_sel, id_fwd_rs2_sel,
               ex_fwd_rs1_sel, ex_fwd_rs2_sel, slot_valid, stall_cnt
    );

endinterface

// File: rtl/panda_hazard_scoreboard_match.sv
// Youngest-writer priority finder for one source operand across all tracked slots.
module panda_sb_match
    import panda_hazard_scoreboard_pkg::*;
#(
    parameter int Depth = 3,
    parameter int RegW  = 5,
    parameter int LatW  = 2
) (
    input  logic [Depth-1:0]           slot_valid,
    input  logic [Depth-1:0][RegW-1:0] slot_rd,
    input  logic [Depth-1:0][LatW-1:0] slot_lat,
    input  logic [RegW-1:0]            src_addr,
    input  src_use_e                   src_use,
    output logic                       hit,
    output logic [LatW-1:0]            idx,
    output logic [LatW-1:0]            lat
);

    logic             en_s;
    logic [Depth-1:0] cand_s;

    assign en_s = (src_use != SRC_NONE) && (src_addr != '0);

    // per-slot candidate vector
    always_comb begin
        cand_s = '0;
        for (int k = 0; k < Depth; k++) begin
            cand_s[k] = en_s && slot_valid[k] && (slot_rd[k] == src_addr);
        end
    end

    // scan oldest to youngest so the lowest index overrides
    always_comb begin
        hit = 1'b0;
        idx = '0;
        lat = '0;
        for (int k = Depth - 1; k >= 0; k--) begin
            hit = cand_s[k] ? 1'b1 : hit;
            idx = cand_s[k] ? LatW'(k) : idx;
            lat = cand_s[k] ? slot_lat[k] : lat;
        end
    end

endmodule

// File: rtl/panda_hazard_scoreboard.sv
// Shift-register hazard/forwarding scoreboard beside the decode stage.
// Build option: PANDA_SB_PERF_EN adds a saturating stall-cycle counter.
module panda_hazard_scoreboard
    import panda_hazard_scoreboard_pkg::*;
#(
    parameter int Depth   = SB_DEPTH,
    parameter int NumRegs = SB_NUM_REGS,
    parameter int LatW    = $clog2(Depth + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    panda_hazard_scoreboard_if.slave sb
);

    localparam int RegW = $clog2(NumRegs);
    localparam logic [LatW-1:0] DEPTH_L  = LatW'(Depth);
    localparam logic [LatW-1:0] LAST_IDX = LatW'(Depth - 1);

    typedef struct packed {
        logic            valid;
        logic [RegW-1:0] rd_addr;
        logic [LatW-1:0] lat;
    } slot_t;

    slot_t [Depth-1:0]           slot_r;
    slot_t                       slot_in_s;
    logic  [Depth-1:0]           v_s;
    logic  [Depth-1:0][RegW-1:0] rd_s;
    logic  [Depth-1:0][LatW-1:0] lat_s;

    logic     [1:0][RegW-1:0] src_addr_s;
    src_use_e                 src_use_s [2];
    logic     [1:0]           hit_s;
    logic     [1:0][LatW-1:0] idx_s;
    logic     [1:0][LatW-1:0] mlat_s;
    logic     [1:0]           hazard_s;
    logic     [1:0][LatW-1:0] id_sel_s;
    logic     [1:0][LatW-1:0] ex_nxt_s;
    logic     [1:0][LatW-1:0] ex_sel_r;
    logic                     stall_s;
    logic                     issue_s;

    // unpack slot fields for the matchers
    always_comb begin
        v_s   = '0;
        rd_s  = '0;
        lat_s = '0;
        for (int k = 0; k < Depth; k++) begin
            v_s[k]   = slot_r[k].valid;
            rd_s[k]  = slot_r[k].rd_addr;
            lat_s[k] = slot_r[k].lat;
        end
    end

    assign src_addr_s[0] = sb.rs1_addr;
    assign src_addr_s[1] = sb.rs2_addr;
    assign src_use_s[0]  = sb.rs1_use;
    assign src_use_s[1]  = sb.rs2_use;

    for (genvar s = 0; s < 2; s++) begin : g_src
        panda_sb_match #(.Depth(Depth), .RegW(RegW), .LatW(LatW)) u_match (
            .slot_valid (v_s),
            .slot_rd    (rd_s),
            .slot_lat   (lat_s),
            .src_addr   (src_addr_s[s]),
            .src_use    (src_use_s[s]),
            .hit        (hit_s[s]),
            .idx        (idx_s[s]),
            .lat        (mlat_s[s])
        );
    end

    // hazard and forward-select decision per source
    always_comb begin
        hazard_s = '0;
        id_sel_s = '0;
        ex_nxt_s = '0;
        for (int s = 0; s < 2; s++) begin
            case (src_use_s[s])
                SRC_ID: begin
                    if (hit_s[s] && (idx_s[s] >= mlat_s[s])) begin
                        id_sel_s[s] = idx_s[s] + LatW'(1);
                    end else begin
                        hazard_s[s] = hit_s[s];
                    end
                end
                SRC_EX: begin
                    if (hit_s[s] && ((idx_s[s] + LatW'(1)) < mlat_s[s])) begin
                        hazard_s[s] = 1'b1;
                    end else if (hit_s[s] && (idx_s[s] < LAST_IDX)) begin
                        ex_nxt_s[s] = idx_s[s] + LatW'(2);
                    end else begin
                        ex_nxt_s[s] = '0;
                    end
                end
                default: begin
                    hazard_s[s] = 1'b0;
                end
            endcase
        end
    end

    assign stall_s = sb.issue_valid & (|hazard_s) & ~sb.flush;
    assign issue_s = sb.issue_valid & ~stall_s & ~sb.flush;

    // new slot 0 content; latencies past the pipe are clamped so they never forward
    always_comb begin
        slot_in_s.valid   = issue_s & sb.issue_rd_we & (sb.issue_rd_addr != '0);
        slot_in_s.rd_addr = sb.issue_rd_addr;
        if (sb.issue_lat > DEPTH_L) begin
            slot_in_s.lat = DEPTH_L;
        end else begin
            slot_in_s.lat = sb.issue_lat;
        end
    end

    // slot shift register and EX forward-select registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_r   <= '0;
            ex_sel_r <= '0;
        end else begin
            slot_r[0] <= slot_in_s;
            for (int k = 1; k < Depth; k++) begin
                slot_r[k] <= slot_r[k-1];
            end
            ex_sel_r[0] <= issue_s ? ex_nxt_s[0] : '0;
            ex_sel_r[1] <= issue_s ? ex_nxt_s[1] : '0;
        end
    end

    assign sb.stall          = stall_s;
    assign sb.id_fwd_rs1_sel = id_sel_s[0];
    assign sb.id_fwd_rs2_sel = id_sel_s[1];
    assign sb.ex_fwd_rs1_sel = ex_sel_r[0];
    assign sb.ex_fwd_rs2_sel = ex_sel_r[1];
    assign sb.slot_valid     = v_s;

`ifdef PANDA_SB_PERF_EN
    logic [31:0] stall_cnt_r;

    // saturating stall-cycle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= 32'd0;
        end else if (stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end
    end

    assign sb.stall_cnt = stall_cnt_r;
`else
    assign sb.stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_panda_hazard_scoreboard.sv
// Directed scoreboard bench: expected EX selects are queued at issue and checked a cycle later.
module tb_panda_hazard_scoreboard;
    import panda_hazard_scoreboard_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    panda_hazard_scoreboard_if #(.Depth(3), .NumRegs(32)) sb_if ();

    panda_hazard_scoreboard #(.Depth(3), .NumRegs(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (sb_if)
    );

    int         n_checks   = 0;
    int         n_pass     = 0;
    int         exp_stalls = 0;
    logic [3:0] ex_q [$];

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic we, input logic [1:0] lat,
                         input logic [4:0] r1, input logic [1:0] u1,
                         input logic [4:0] r2, input logic [1:0] u2, input logic fl);
        sb_if.issue_valid   = v;
        sb_if.issue_rd_addr = rd;
        sb_if.issue_rd_we   = we;
        sb_if.issue_lat     = lat;
        sb_if.rs1_addr      = r1;
        sb_if.rs1_use       = src_use_e'(u1);
        sb_if.rs2_addr      = r2;
        sb_if.rs2_use       = src_use_e'(u2);
        sb_if.flush         = fl;
    endtask

    // One ID cycle: drive, check combinational outputs, check last cycle's EX selects, queue this one's.
    task automatic step(input string tag, input logic v, input logic [4:0] rd, input logic we,
                        input logic [1:0] lat, input logic [4:0] r1, input logic [1:0] u1,
                        input logic [4:0] r2, input logic [1:0] u2, input logic fl,
                        input logic es, input logic [1:0] eid1, input logic [1:0] eid2,
                        input logic [1:0] eex1, input logic [1:0] eex2);
        logic [3:0] e;
        @(posedge clk);
        #1;
        drive(v, rd, we, lat, r1, u1, r2, u2, fl);
        @(negedge clk);
        check_value({tag, ".stall"}, {31'd0, sb_if.stall}, {31'd0, es});
        check_value({tag, ".id1"}, {30'd0, sb_if.id_fwd_rs1_sel}, {30'd0, eid1});
        check_value({tag, ".id2"}, {30'd0, sb_if.id_fwd_rs2_sel}, {30'd0, eid2});
        if (ex_q.size() == 0) begin
            $display("FAIL %s.exq: scoreboard queue empty, expected 1 entry", tag);
            $fatal(1);
        end
        e = ex_q.pop_front();
        check_value({tag, ".ex1"}, {30'd0, sb_if.ex_fwd_rs1_sel}, {30'd0, e[3:2]});
        check_value({tag, ".ex2"}, {30'd0, sb_if.ex_fwd_rs2_sel}, {30'd0, e[1:0]});
        ex_q.push_back({eex1, eex2});
        if (es) exp_stalls++;
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 5'd0, 1'b0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) idle("drain");
    endtask

    initial begin
        logic [31:0] exp_cnt;
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_value("rst.stall", {31'd0, sb_if.stall}, 32'd0);
        check_value("rst.slot_valid", {29'd0, sb_if.slot_valid}, 32'd0);
        check_value("rst.ex1", {30'd0, sb_if.ex_fwd_rs1_sel}, 32'd0);
        check_value("rst.stall_cnt", sb_if.stall_cnt, 32'd0);
        rst_n = 1'b1;
        ex_q.push_back(4'd0);

        // ALU result forwarded to EX consumer without stall
        step("t1_alu", 1, 5'd5, 1, 2'd1, 5'd0, 2'd0, 5'd0, 2'd0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0);
        step("t1_use", 1, 5'd9, 1, 2'd1, 5'd5, 2'd1, 5'd0, 2'd0, 0, 0, 2'd0, 2'd0, 2'd2, 2'd0);
        idle("t1_ex");
        check_value("t1.slot_valid", {29'd0, sb_if.slot_valid}, 32'd3);
        drain();

        // load-use: one stall, then forward from slot 1
        step("t2_ld", 1, 5'd6, 1, 2'd2, 5'd0, 2'd0, 5'd0, 2'd0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0);
        step("t2_stall", 1, 5'd10, 1, 2'd1, 5'd6, 2'd1, 5'd0, 2'd0, 0, 1, 2'd0, 2'd0, 2'd0, 2'd0);
        step("t2_go", 1, 5'd10, 1, 2'd1, 5'd6, 2'd1, 5'd0, 2'd0, 0, 0, 2'd0, 2'd0, 2'd3, 2'd0);
        idle("t2_ex");
        drain();

        // branch after ALU: one stall; branch after load: two stalls
        step("t3_alu", 1, 5'd7, 1, 2'd1, 5'd0, 2'd0, 5'd0, 2'd0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0);
        step("t3_br_s", 1, 5'd0, 0, 2'd1, 5'd7, 2'd2, 5'd0, 2'd0, 0, 1, 2'd0, 2'd0, 2'd0, 2'd0);
        step("t3_br_go", 1, 5'd0, 0, 2'd1, 5'd7, 2'd2, 5'd0, 2'd0, 0, 0, 2'd2, 2'd0, 2'd0, 2'd0);
        drain();
        step("t3_ld", 1, 5'd7, 1, 2'd2, 5'd0, 2'd0, 5'd0, 2'd0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0);
        step("t3_lbr_s1", 1, 5'd0, 0, 2'd1, 5'd0, 2'd0, 5'd7, 2'd2, 0, 1, 2'd0, 2'd0, 2'd0, 2'd0);
        step("t3_lbr_s2", 1, 5'd0, 0, 2'd1, 5'd0, 2'd0, 5'd7, 2'd2, 0, 1, 2'd0, 2'd0, 2'd0, 2'd0);
        step("t3_lbr_go", 1, 5'd0, 0, 2'd1, 5'd0, 2'd0, 5'd7, 2'd2, 0, 0, 2'd0, 2'd3, 2'd0, 2'd0);
        drain();

        // x0 and non-writing instructions are never tracked
        step("t4_x0", 1, 5'd0, 1, 2'd2, 5'd0, 2'd0, 5'd0, 2'd0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0);
        step("t4_nowe", 1, 5'd11, 0, 2'd2, 5'd0, 2'd0, 5'd0, 2'd0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0);
        step("t4_use", 1, 5'd12, 0, 2'd1, 5'd0, 2'd1, 5'd11, 2'd2, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0);
        check_value("t4.slot_valid", {29'd0, sb_if.slot_valid}, 32'd0);
        drain();

        // youngest of two writers wins; flush masks a hazard
        step("t5_a", 1, 5'd8, 1, 2'd1, 5'd0, 2'd0, 5'd0, 2'd0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0);
        step("t5_b", 1, 5'd8, 1, 2'd1, 5'd0, 2'd0, 5'd0, 2'd0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0);
        step("t5_use", 1, 5'd0, 0, 2'd1, 5'd8, 2'd1, 5'd8, 2'd1, 0, 0, 2'd0, 2'd0, 2'd2, 2'd2);
        idle("t5_ex");
        drain();
        step("t5_ld", 1, 5'd12, 1, 2'd2, 5'd0, 2'd0, 5'd0, 2'd0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0);
        step("t5_flush", 1, 5'd13, 1, 2'd1, 5'd12, 2'd1, 5'd0, 2'd0, 1, 0, 2'd0, 2'd0, 2'd0, 2'd0);
        idle("t5_after");
        check_value("t5.slot_valid", {29'd0, sb_if.slot_valid}, 32'd2);
        drain();

        // latency equal to depth: never forwarded, resolves through the regfile
        step("t7_lat3", 1, 5'd14, 1, 2'd3, 5'd0, 2'd0, 5'd0, 2'd0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0);
        step("t7_s1", 1, 5'd15, 1, 2'd1, 5'd14, 2'd1, 5'd0, 2'd0, 0, 1, 2'd0, 2'd0, 2'd0, 2'd0);
        step("t7_s2", 1, 5'd15, 1, 2'd1, 5'd14, 2'd1, 5'd0, 2'd0, 0, 1, 2'd0, 2'd0, 2'd0, 2'd0);
        step("t7_go", 1, 5'd15, 1, 2'd1, 5'd14, 2'd1, 5'd0, 2'd0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0);
        idle("t7_ex");
        drain();

`ifdef PANDA_SB_PERF_EN
        exp_cnt = 32'(exp_stalls);
`else
        exp_cnt = 32'd0;
`endif
        check_value("perf.stall_cnt", sb_if.stall_cnt, exp_cnt);

        // asynchronous reset in the middle of a load-use stall
        step("t6_ld", 1, 5'd6, 1, 2'd2, 5'd0, 2'd0, 5'd0, 2'd0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0);
        step("t6_stall", 1, 5'd10, 1, 2'd1, 5'd6, 2'd1, 5'd0, 2'd0, 0, 1, 2'd0, 2'd0, 2'd0, 2'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_value("t6.stall", {31'd0, sb_if.stall}, 32'd0);
        check_value("t6.slot_valid", {29'd0, sb_if.slot_valid}, 32'd0);
        check_value("t6.ex1", {30'd0, sb_if.ex_fwd_rs1_sel}, 32'd0);
        check_value("t6.stall_cnt", sb_if.stall_cnt, 32'd0);
        drive(1'b0, 5'd0, 1'b0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ex_q.delete();
        ex_q.push_back(4'd0);
        step("t6_post", 1, 5'd6, 1, 2'd1, 5'd6, 2'd1, 5'd0, 2'd0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/panda_hazard_scoreboard.md
Name: panda_hazard_scoreboard

Overview:
Parametrised hazard and forwarding scoreboard for the Panda pipeline. It replaces fixed-depth, hard-wired load-use and RAW compare logic with a shift-register tracker of in-flight destination registers. Each tracked instruction carries a per-instruction result latency. The block sits beside the decode stage and drives the IF/ID stall, early-use (ID) forwarding selects and registered EX forwarding selects for any number of post-decode stages.

Parameters:
Depth, 3, number of tracked pipeline registers after ID (slot 0 = ID/EX, slot 1 = EX/MEM, slot Depth-1 = last before regfile write)
NumRegs, 32, architectural register count; register 0 is hard-wired zero
LatW, $clog2(Depth+1), width of latency and forward-select fields

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
issue_valid_i  in  1  ID holds a valid instruction this cycle
issue_rd_addr_i  in  $clog2(NumRegs)  destination of ID instruction
issue_rd_we_i  in  1  ID instruction writes rd
issue_lat_i  in  LatW  first slot index whose forward bus carries the result (ALU=1, load=2)
rs1_addr_i, rs2_addr_i  in  $clog2(NumRegs) each  ID sources
rs1_use_i, rs2_use_i  in  2 each  00 unused, 01 needed in EX, 10 needed in ID (branch/jalr)
flush_i  in  1  discard ID instruction (insert bubble)
stall_o  out  1  hold IF/ID, bubble into ID/EX
id_fwd_rs1_sel_o, id_fwd_rs2_sel_o  out  LatW each  0 regfile, j+1 = slot j bus (combinational)
ex_fwd_rs1_sel_o, ex_fwd_rs2_sel_o  out  LatW each  same encoding, registered for the instruction now in EX
slot_valid_o  out  Depth  per-slot valid, debug
stall_cnt_o  out  32  stall-cycle count (see Optional Feature)

Behaviour:
- Slot state is {valid, rd_addr, lat}. A slot is a writer if valid, rd_we was set at issue, and rd_addr != 0. Only writers are stored as valid.
- Every edge, slot[k] <= slot[k-1] for k >= 1. Slot[Depth-1] retires; the regfile is written on that same edge.
- slot[0] receives the ID instruction if issue_valid_i & ~stall_o & ~flush_i; otherwise it receives a bubble.
- Match per source: search slots 0..Depth-1 and take the youngest (lowest k) writer whose rd_addr equals the source. A source of 0, or use=00, never matches.
- Early use (10): match at k with k >= lat gives id sel = k+1. k < lat is a hazard. No match gives sel 0.
- EX use (01): match at k with k+1 < lat is a hazard. Otherwise the next-cycle EX sel = k+2 if k+1 <= Depth-1, else 0. No match gives sel 0.
- id sel is 0 for any source not in early use.
- stall_o = issue_valid_i & (any hazard) & ~flush_i. flush_i has priority over stall.
- ex sel registers load on every edge. They load 0 when the ID instruction is not issued into slot 0.
- Latency: stall_o and id sels are combinational, zero cycles. ex sels are valid one cycle after issue.
- Reset (asynchronous, any time, including mid-stall): all slots invalid; stall_o=0; all sels 0; stall_cnt_o=0.
- issue_lat_i > Depth is clamped to Depth. Such an instruction is never forwardable and resolves only via the regfile.

Optional Feature:
PANDA_SB_PERF_EN: when defined, stall_cnt_o is a 32-bit counter that increments on each cycle with stall_o=1 and saturates at 0xFFFFFFFF. When undefined, stall_cnt_o is tied to 0 and no counter flops exist.

Decomposition:
- panda_pkg gains:
  - src_use_e (SRC_NONE, SRC_EX, SRC_ID)
  - LAT_ALU=1 and LAT_LOAD=2
  - parametrised slot struct sb_slot_t
- Sub-module panda_sb_match: youngest-match priority finder for one source. Outputs hit, slot index and lat. Instantiated once per source.

Test Plan:
1. Depth=3. Issue ALU writing x5 (lat 1); next cycle issue an instruction reading x5 with EX use -> stall_o=0; the following cycle ex_fwd_rs1_sel_o=2.
2. Issue load writing x6 (lat 2); next cycle issue an instruction reading x6 with EX use -> stall_o=1 for exactly one cycle. Then issue succeeds with ex_fwd_rs1_sel_o=3.
3. ALU writing x7 followed by a branch reading x7 (early use) -> stall 1 cycle, then id_fwd_rs1_sel_o=2. A load writing x7 followed by a branch -> stall 2 cycles, then sel=3.
4. rd_addr=0 or rd_we=0 writer, then a consumer of x0 -> never stalls, all sels 0.
5. Two writers of x8 in slots 0 and 1 -> consumer sels derive from slot 0 (youngest). flush_i together with a hazard -> stall_o=0 and slot 0 bubble.
6. Assert rst_ni low during a load-use stall -> stall_o=0 and slot_valid_o=0 immediately; stall_cnt_o=0 when PANDA_SB_PERF_EN is defined.
